// File: rtl/lfsr_crypt_engine.sv
// LFSR stream-cipher engine: loads preamble length, taps and seed from memory, then
// encrypts (PAD preamble + scrambled message) or decrypts (strips preamble) in place.
module lfsr_crypt_engine #(
  parameter int DW       = 8,
  parameter int LW       = 6,
  parameter int AW       = 8,
  parameter int MSG_LEN  = 50,
  parameter int SRC_BASE = 0,
  parameter int CFG_BASE = 61,
  parameter int DST_BASE = 64,
  parameter logic [DW-1:0] PAD = DW'(8'h5f)
) (
  input  logic          clk,
  input  logic          init,
  input  logic          start,
  input  logic          mode,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata,
  output logic          busy,
  output logic          done,
  output logic [LW-1:0] lfsr_state,
  output logic [7:0]    pre_seen
);

  localparam int CW_MIN = $clog2(256 + MSG_LEN);
  localparam int CW     = (AW > CW_MIN) ? AW : CW_MIN;

  typedef enum logic [2:0] {
    IDLE, LD_PRE, LD_TAPS, LD_SEED, ARM, PRE, BODY, DONE
  } state_t;

  state_t        state, state_nxt;
  logic          mode_q;
  logic [7:0]    pre_len;
  logic [LW-1:0] taps, seed, lfsr, lfsr_nxt;
  logic [CW-1:0] src, dst, bcnt;
  logic [DW-1:0] key, plain;
  logic          lfsr_adv, src_inc, dst_inc, pre_inc, bcnt_inc;

  assign lfsr_nxt   = {lfsr[LW-2:0], ^(lfsr & taps)};
  assign key        = DW'(lfsr);
  assign plain      = mem_rdata ^ key;
  assign busy       = (state != IDLE) && (state != DONE);
  assign done       = (state == DONE);
  assign lfsr_state = lfsr;

  always_comb begin
    state_nxt = state;
    mem_raddr = '0;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    lfsr_adv  = 1'b0;
    src_inc   = 1'b0;
    dst_inc   = 1'b0;
    pre_inc   = 1'b0;
    bcnt_inc  = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = LD_PRE;
      LD_PRE:  begin
        mem_raddr = AW'(CFG_BASE);
        state_nxt = LD_TAPS;
      end
      LD_TAPS: begin
        mem_raddr = AW'(CFG_BASE + 1);
        state_nxt = LD_SEED;
      end
      LD_SEED: begin
        mem_raddr = AW'(CFG_BASE + 2);
        state_nxt = ARM;
      end
      ARM:     state_nxt = (pre_len == 8'd0) ? BODY : PRE;
      PRE: begin
        if (!mode_q) begin
          mem_we    = 1'b1;
          mem_waddr = AW'(DST_BASE) + dst[AW-1:0];
          mem_wdata = PAD ^ key;
          lfsr_adv  = 1'b1;
          dst_inc   = 1'b1;
          pre_inc   = 1'b1;
          if (pre_seen == pre_len - 8'd1) state_nxt = BODY;
        end else begin
          mem_raddr = AW'(SRC_BASE) + src[AW-1:0];
          if (plain == PAD && pre_seen < pre_len) begin
            lfsr_adv = 1'b1;
            src_inc  = 1'b1;
            pre_inc  = 1'b1;
          end else begin
            // Exit without consuming: BODY re-reads this source word with the same key.
            state_nxt = BODY;
          end
        end
      end
      BODY: begin
        mem_raddr = AW'(SRC_BASE) + src[AW-1:0];
        mem_we    = 1'b1;
        mem_waddr = AW'(DST_BASE) + dst[AW-1:0];
        mem_wdata = plain;
        lfsr_adv  = 1'b1;
        src_inc   = 1'b1;
        dst_inc   = 1'b1;
        bcnt_inc  = 1'b1;
        if (bcnt == CW'(MSG_LEN - 1)) state_nxt = DONE;
      end
      DONE:    if (start) state_nxt = LD_PRE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      state    <= IDLE;
      mode_q   <= 1'b0;
      pre_len  <= '0;
      taps     <= '0;
      seed     <= '0;
      lfsr     <= '0;
      src      <= '0;
      dst      <= '0;
      bcnt     <= '0;
      pre_seen <= '0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE || state == DONE) && start) mode_q <= mode;
      if (state == LD_PRE)  pre_len <= 8'(mem_rdata);
      if (state == LD_TAPS) taps    <= mem_rdata[LW-1:0];
      // An all-zero seed would lock the register up, so it loads as 1.
      if (state == LD_SEED)
        seed <= (mem_rdata[LW-1:0] == '0) ? LW'(1) : mem_rdata[LW-1:0];
      if (state == ARM) begin
        lfsr     <= seed;
        src      <= '0;
        dst      <= '0;
        bcnt     <= '0;
        pre_seen <= '0;
      end else begin
        if (lfsr_adv) lfsr     <= lfsr_nxt;
        if (src_inc)  src      <= src + CW'(1);
        if (dst_inc)  dst      <= dst + CW'(1);
        if (bcnt_inc) bcnt     <= bcnt + CW'(1);
        if (pre_inc)  pre_seen <= pre_seen + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_crypt_engine.sv
// Directed bench for lfsr_crypt_engine with a behavioural memory (combinational read,
// synchronous write) and hand-computed expectations plus a small key-sequence model.
module tb_lfsr_crypt_engine;

  logic       clk = 1'b0;
  logic       init, start, mode;
  logic [7:0] mem_raddr, mem_rdata, mem_waddr, mem_wdata;
  logic       mem_we, busy, done;
  logic [5:0] lfsr_state;
  logic [7:0] pre_seen;

  logic       tb_we;
  logic [7:0] tb_waddr, tb_wdata;
  logic [7:0] mem  [256];
  logic [7:0] orig [64];

  int         n_tests = 0;
  int         n_fail  = 0;
  int         lat;
  logic [5:0] first_k;

  always #5 clk = ~clk;

  lfsr_crypt_engine dut (
    .clk        (clk),
    .init       (init),
    .start      (start),
    .mode       (mode),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .lfsr_state (lfsr_state),
    .pre_seen   (pre_seen)
  );

  assign mem_rdata = mem[mem_raddr];

  always @(posedge clk)
    if (mem_we)     mem[mem_waddr] <= mem_wdata;
    else if (tb_we) mem[tb_waddr]  <= tb_wdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] step(input logic [5:0] s, input logic [5:0] t);
    return {s[4:0], ^(s & t)};
  endfunction

  task automatic mem_wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
    @(posedge clk);
    #1 tb_we = 1'b0;
  endtask

  task automatic set_cfg(input logic [7:0] pre, input logic [7:0] taps, input logic [7:0] seed);
    mem_wr(8'd61, pre);
    mem_wr(8'd62, taps);
    mem_wr(8'd63, seed);
  endtask

  task automatic fill_dst();
    for (int i = 64; i < 128; i++) mem_wr(8'(i), 8'hEE);
  endtask

  task automatic set_msg(input int kind);
    logic [7:0] v;
    for (int i = 0; i < 60; i++) begin
      case (kind)
        0:       v = 8'(8'h41 + i);
        1:       v = 8'(i * 37 + 11);
        default: v = (i < 2) ? 8'h5f : 8'(8'h30 + i);
      endcase
      orig[i] = v;
      mem_wr(8'(i), v);
    end
  endtask

  task automatic copy_back(input int n);
    for (int i = 0; i < n; i++) mem_wr(8'(i), mem[64 + i]);
  endtask

  task automatic check_cipher(input string tag, input int pre, input logic [5:0] taps,
                              input logic [5:0] seed);
    logic [5:0] k;
    int errs;
    errs = 0;
    k = (seed == 6'd0) ? 6'd1 : seed;
    for (int i = 0; i < pre; i++) begin
      if (mem[64 + i] !== (8'h5f ^ {2'b00, k})) errs++;
      k = step(k, taps);
    end
    for (int i = 0; i < 50; i++) begin
      if (mem[64 + pre + i] !== (orig[i] ^ {2'b00, k})) errs++;
      k = step(k, taps);
    end
    chk(tag, errs, 0);
  endtask

  task automatic check_plain(input string tag);
    int errs;
    errs = 0;
    for (int i = 0; i < 50; i++) if (mem[64 + i] !== orig[i]) errs++;
    chk(tag, errs, 0);
  endtask

  task automatic run(input logic m, input int exp_lat, input bit poke, input string tag);
    @(negedge clk);
    start = 1'b1; mode = m;
    @(negedge clk);
    start = 1'b0; mode = ~m;
    chk({tag, "_busy"}, busy, 1);
    lat = -1;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      start = poke && (n == 10);
      if (n == 4) first_k = lfsr_state;
      if (done) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
    chk({tag, "_lat"}, lat, exp_lat);
  endtask

  initial begin
    init = 1'b0; start = 1'b0; mode = 1'b0;
    tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;
    #1 init = 1'b1;
    #12;
    chk("rst_we",     mem_we,     0);
    chk("rst_busy",   busy,       0);
    chk("rst_done",   done,       0);
    chk("rst_lfsr",   lfsr_state, 0);
    chk("rst_preseen", pre_seen,  0);
    chk("rst_addr",   {mem_raddr, mem_waddr, mem_wdata}, 0);
    @(negedge clk);
    init = 1'b0;

    // Encrypt basic, with a stray start while busy.
    set_msg(0); fill_dst(); set_cfg(8'd2, 8'h30, 8'h01);
    run(1'b0, 56, 1'b1, "t1");
    chk("t1_m64", mem[64], 8'h5e);
    chk("t1_m65", mem[65], 8'h5d);
    chk("t1_m66", mem[66], 8'h45);
    chk("t1_preseen", pre_seen, 2);
    check_cipher("t1_all", 2, 6'h30, 6'h01);
    chk("t1_m116", mem[116], 8'hEE);
    repeat (3) @(negedge clk);
    chk("t1_done_hold", {busy, done}, 2'b01);

    // No preamble.
    fill_dst(); set_cfg(8'd0, 8'h21, 8'h05);
    run(1'b0, 54, 1'b0, "t2");
    chk("t2_m64", mem[64], 8'h44);
    chk("t2_m65", mem[65], 8'h49);
    chk("t2_m114", mem[114], 8'hEE);
    chk("t2_preseen", pre_seen, 0);
    check_cipher("t2_all", 0, 6'h21, 6'h05);

    // Zero seed behaves as seed 1.
    fill_dst(); set_cfg(8'd2, 8'h30, 8'h00);
    run(1'b0, 56, 1'b0, "t3");
    chk("t3_firstk", first_k, 6'h01);
    chk("t3_m64", mem[64], 8'h5e);
    chk("t3_m66", mem[66], 8'h45);
    check_cipher("t3_all", 2, 6'h30, 6'h00);

    // Round trip.
    set_msg(1); fill_dst(); set_cfg(8'd10, 8'h21, 8'h2a);
    run(1'b0, 64, 1'b0, "t4e");
    check_cipher("t4e_all", 10, 6'h21, 6'h2a);
    copy_back(60); fill_dst();
    run(1'b1, 65, 1'b0, "t4d");
    chk("t4d_preseen", pre_seen, 10);
    check_plain("t4d_plain");
    chk("t4d_m114", mem[114], 8'hEE);

    // Decrypt strips no more than pre_len PAD characters.
    set_msg(2); fill_dst(); set_cfg(8'd1, 8'h30, 8'h07);
    run(1'b0, 55, 1'b0, "t5e");
    copy_back(51); fill_dst();
    run(1'b1, 56, 1'b0, "t5d");
    chk("t5d_preseen", pre_seen, 1);
    chk("t5d_m64", mem[64], 8'h5f);
    chk("t5d_m65", mem[65], 8'h5f);
    chk("t5d_m66", mem[66], 8'h32);
    check_plain("t5d_plain");

    // Asynchronous abort in the fourth preamble cycle, then a clean rerun.
    set_msg(0); fill_dst(); set_cfg(8'd10, 8'h30, 8'h01);
    @(negedge clk);
    start = 1'b1; mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("t6_pre_we", mem_we, 1);
    chk("t6_pre_waddr", mem_waddr, 8'd67);
    #2 init = 1'b1;
    #1;
    chk("t6_rst_we", mem_we, 0);
    chk("t6_rst_busy_done", {busy, done}, 2'b00);
    @(negedge clk);
    @(negedge clk);
    init = 1'b0;
    chk("t6_m66", mem[66], 8'h5b);
    chk("t6_m67", mem[67], 8'hEE);
    run(1'b0, 64, 1'b0, "t6r");
    chk("t6r_m67", mem[67], 8'h57);
    chk("t6r_preseen", pre_seen, 10);
    check_cipher("t6r_all", 10, 6'h30, 6'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
